fpadd_pipe: RTL and testbench

FPADD_PIPE -- requirements
Module: fpadd_pipe

---
 rtl/fpadd_pipe_if.sv | 31 +++
 rtl/fpadd_pipe.sv | 183 ++++++++++++++++++
 tb/tb_fpadd_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpadd_pipe_if.sv
// Handshake and data bundle for the pipelined floating-point adder.
// The master drives operands and accepts results; the slave is the adder.
interface fpadd_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_inexact;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_inexact
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_inexact
  );
endinterface

// File: rtl/fpadd_pipe.sv
// Three-stage floating-point adder/subtractor with round-to-nearest-even.
// S1 unpacks, orders operands by magnitude and aligns the smaller one;
// S2 adds or subtracts the aligned mantissas; S3 normalises and rounds.
// A single global stall freezes every stage while the result is not taken.
module fpadd_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input logic         clk,
  input logic         reset,
  fpadd_pipe_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  // hidden bit + mantissa + guard/round/sticky
  localparam int MX = MAN_W + 4;
  // one extra carry bit on top of the extended mantissa
  localparam int SW = MAN_W + 5;
  localparam logic [31:0] SH_MAX = 32'(MAN_W + 3);

  logic stall;

  // S1 combinational
  logic             a_sign, b_sign, a_is_l;
  logic [EXP_W-1:0] a_exp, b_exp, l_exp, s_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic [MX-1:0]    l_ext, s_ext;
  logic [31:0]      shamt;
  logic [2*MX-1:0]  s_wide;
  logic             s1_sign_d, s1_sub_d;
  logic [EXP_W-1:0] s1_exp_d;
  logic [MX-1:0]    s1_ml_d, s1_ms_d;

  // S1 registers
  logic             s1_valid_q, s1_sign_q, s1_sub_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [MX-1:0]    s1_ml_q, s1_ms_q;
  logic [TAG_W-1:0] s1_tag_q;

  // S2
  logic [SW-1:0]    s2_sum_d;
  logic             s2_valid_q, s2_sign_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [SW-1:0]    s2_sum_q;
  logic [TAG_W-1:0] s2_tag_q;

  // S3 combinational
  logic [EXP_W-1:0] lz, n_exp, f_exp;
  logic [MX-1:0]    norm;
  logic [MAN_W:0]   man_r;
  logic             rnd_up, ovf, is_zero, inx_d;
  logic [W-1:0]     res_d;

  // S3 / output registers
  logic             out_valid_q, out_inexact_q;
  logic [W-1:0]     out_result_q;
  logic [TAG_W-1:0] out_tag_q;

  assign stall           = out_valid_q & ~bus.out_ready;
  assign bus.in_ready    = ~stall;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_tag     = out_tag_q;
  assign bus.out_inexact = out_inexact_q;

  // S1: unpack, pick the larger magnitude as L, align S with a sticky bit
  always_comb begin
    a_sign = bus.in_a[W-1];
    a_exp  = bus.in_a[W-2 -: EXP_W];
    a_man  = bus.in_a[MAN_W-1:0];
    b_sign = bus.in_b[W-1] ^ bus.in_sub;
    b_exp  = bus.in_b[W-2 -: EXP_W];
    b_man  = bus.in_b[MAN_W-1:0];
    a_is_l = {a_exp, a_man} >= {b_exp, b_man};
    // a zero exponent means a zero operand, so its hidden bit is clear
    if (a_is_l) begin
      l_exp     = a_exp;
      s_exp     = b_exp;
      l_ext     = {|a_exp, a_man, 3'b000};
      s_ext     = {|b_exp, b_man, 3'b000};
      s1_sign_d = a_sign;
    end else begin
      l_exp     = b_exp;
      s_exp     = a_exp;
      l_ext     = {|b_exp, b_man, 3'b000};
      s_ext     = {|a_exp, a_man, 3'b000};
      s1_sign_d = b_sign;
    end
    shamt = 32'(l_exp - s_exp);
    if (shamt > SH_MAX) shamt = SH_MAX;
    s_wide   = {s_ext, {MX{1'b0}}} >> shamt;
    s1_ms_d  = {s_wide[2*MX-1:MX+1], s_wide[MX] | (|s_wide[MX-1:0])};
    s1_ml_d  = l_ext;
    s1_exp_d = l_exp;
    s1_sub_d = a_sign ^ b_sign;
  end

  // S1 register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_sub_q   <= 1'b0;
      s1_exp_q   <= '0;
      s1_ml_q    <= '0;
      s1_ms_q    <= '0;
      s1_tag_q   <= '0;
    end else if (!stall) begin
      s1_valid_q <= bus.in_valid;
      s1_sign_q  <= s1_sign_d;
      s1_sub_q   <= s1_sub_d;
      s1_exp_q   <= s1_exp_d;
      s1_ml_q    <= s1_ml_d;
      s1_ms_q    <= s1_ms_d;
      s1_tag_q   <= bus.in_tag;
    end
  end

  // S2: magnitude add or L-S; L >= S so the difference never goes negative
  always_comb begin
    s2_sum_d = s1_sub_q ? ({1'b0, s1_ml_q} - {1'b0, s1_ms_q})
                        : ({1'b0, s1_ml_q} + {1'b0, s1_ms_q});
  end

  // S2 register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_sum_q   <= '0;
      s2_tag_q   <= '0;
    end else if (!stall) begin
      s2_valid_q <= s1_valid_q;
      s2_sign_q  <= s1_sign_q;
      s2_exp_q   <= s1_exp_q;
      s2_sum_q   <= s2_sum_d;
      s2_tag_q   <= s1_tag_q;
    end
  end

  // S3: normalise (carry right-shift or leading-zero left-shift), then RNE round
  always_comb begin
    lz = '0;
    for (int i = 0; i < MX; i++) begin
      if (s2_sum_q[i]) lz = EXP_W'(MX - 1 - i);
    end
    if (s2_sum_q[SW-1]) begin
      norm  = {s2_sum_q[SW-1:2], s2_sum_q[1] | s2_sum_q[0]};
      n_exp = s2_exp_q + EXP_W'(1);
    end else begin
      norm  = s2_sum_q[MX-1:0] << lz;
      n_exp = s2_exp_q - lz;
    end
    // a normalised nonzero sum always has its top bit set
    is_zero = ~norm[MX-1];
    rnd_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    man_r   = {1'b0, norm[MX-2:3]} + (MAN_W+1)'(rnd_up);
    ovf     = man_r[MAN_W];
    f_exp   = ovf ? n_exp + EXP_W'(1) : n_exp;
    inx_d   = |norm[2:0];
    res_d   = {s2_sign_q, f_exp, man_r[MAN_W-1:0]};
    if (is_zero) begin
      res_d = '0;
      inx_d = 1'b0;
    end
  end

  // S3 / output register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_tag_q     <= '0;
      out_inexact_q <= 1'b0;
    end else if (!stall) begin
      out_valid_q   <= s2_valid_q;
      out_result_q  <= res_d;
      out_tag_q     <= s2_tag_q;
      out_inexact_q <= inx_d;
    end
  end
endmodule

// File: tb/tb_fpadd_pipe.sv
// Self-checking bench for fpadd_pipe: exact-arithmetic reference model,
// scoreboard compared on every output transfer, directed literal cases,
// backpressure, asynchronous reset with ops in flight and an FP16 instance.
module tb_fpadd_pipe;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   out_count = 0;
  bit   done_rand;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    logic        inx;
  } exp_t;
  exp_t exp_q[$];

  fpadd_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) bus ();
  fpadd_pipe_if #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) bus16 ();

  fpadd_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  fpadd_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16)
  );

  // free-running clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Exact FP32 sum using wide integers, then round-to-nearest-even.
  // A far-smaller operand is pulled up to a 60-bit gap: it is still far below
  // a quarter ulp of the larger one, so the rounded result is unchanged.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                output logic [31:0] res, output logic inx);
    logic sa, sb, az, bz, sgn;
    int ea, eb, emax, fa, fb, base, p, sh, e;
    logic signed [127:0] va, vb, sum;
    logic [127:0] mag, rem, half, mant;
    sa = a[31]; sb = b[31] ^ sub;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    az = (a[30:0] == 31'd0); bz = (b[30:0] == 31'd0);
    inx = 1'b0;
    if (az && bz) res = 32'd0;
    else if (bz) res = a;
    else if (az) res = {sb, b[30:0]};
    else begin
      emax = (ea > eb) ? ea : eb;
      fa = (ea > emax - 60) ? ea : emax - 60;
      fb = (eb > emax - 60) ? eb : emax - 60;
      base = (fa < fb) ? fa : fb;
      va = 128'({1'b1, a[22:0]}) << (fa - base);
      vb = 128'({1'b1, b[22:0]}) << (fb - base);
      if (sa) va = -va;
      if (sb) vb = -vb;
      sum = va + vb;
      if (sum == 0) res = 32'd0;
      else begin
        sgn = sum < 0;
        mag = sgn ? 128'(-sum) : 128'(sum);
        p = 0;
        for (int i = 0; i < 128; i++) if (mag[i]) p = i;
        e = base + p - 23;
        if (p > 23) begin
          sh = p - 23;
          mant = mag >> sh;
          rem = mag & ((128'd1 << sh) - 128'd1);
          half = 128'd1 << (sh - 1);
          inx = (rem != 0);
          if (rem > half || (rem == half && mant[0])) mant = mant + 128'd1;
          if (mant[24]) begin
            mant = mant >> 1;
            e = e + 1;
          end
        end else mant = mag << (23 - p);
        res = {sgn, 8'(e), mant[22:0]};
      end
    end
  endfunction

  // scoreboard: push on input transfer, pop and compare on output transfer
  always @(negedge clk) begin
    logic [31:0] mr, prev_res;
    logic        mi, prev_stall;
    logic [3:0]  prev_tag;
    exp_t        item;
    if (reset) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready_vs_stall", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
      if (prev_stall) begin
        check("stall_hold_valid", 32'(bus.out_valid), 32'd1);
        check("stall_hold_result", bus.out_result, prev_res);
        check("stall_hold_tag", 32'(bus.out_tag), 32'(prev_tag));
      end
      if (bus.in_valid && bus.in_ready) begin
        model(bus.in_a, bus.in_b, bus.in_sub, mr, mi);
        item.res = mr; item.tag = bus.in_tag; item.inx = mi;
        exp_q.push_back(item);
      end
      if (bus.out_valid && bus.out_ready) begin
        out_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(bus.out_valid), 32'd0);
        end else begin
          item = exp_q.pop_front();
          check("sb_result", bus.out_result, item.res);
          check("sb_tag", 32'(bus.out_tag), 32'(item.tag));
          check("sb_inexact", 32'(bus.out_inexact), 32'(item.inx));
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_res = bus.out_result;
      prev_tag = bus.out_tag;
    end
  end

  // hold an operand pair until the DUT takes it; called at posedge+1
  task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [3:0] tag);
    bit acc = 1'b0;
    int n = 0;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_sub = sub; bus.in_tag = tag;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  // single op on an idle pipe: check the model, latency and literal result
  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [3:0] tag,
                         input logic [31:0] exp_res, input logic exp_inx);
    logic [31:0] mr;
    logic mi;
    int n;
    model(a, b, sub, mr, mi);
    check({name, "_model"}, mr, exp_res);
    check({name, "_model_inx"}, 32'(mi), 32'(exp_inx));
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_sub = sub; bus.in_tag = tag;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'd3);
    check({name, "_result"}, bus.out_result, exp_res);
    check({name, "_tag"}, 32'(bus.out_tag), 32'(tag));
    check({name, "_inexact"}, 32'(bus.out_inexact), 32'(exp_inx));
    @(posedge clk);
    #1;
  endtask

  task automatic gen_pair(output logic [31:0] a, output logic [31:0] b, output logic sub);
    int mode, ea, eb;
    mode = int'($urandom_range(0, 7));
    ea = int'($urandom_range(60, 190));
    a = {1'($urandom), 8'(ea), 23'($urandom)};
    sub = 1'($urandom);
    case (mode)
      0: b = {1'($urandom), a[30:0]};
      1: begin
        b = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        if ($urandom % 2 == 0) a = {a[31], 31'd0};
        else b = {b[31], 31'd0};
      end
      5, 6: eb = ea + int'($urandom_range(0, 60)) - 30;
      7: eb = ea + int'($urandom_range(0, 200)) - 100;
      default: eb = ea + int'($urandom_range(0, 6)) - 3;
    endcase
    if (mode > 1) begin
      if (eb < 20) eb = 20;
      if (eb > 230) eb = 230;
      b = {1'($urandom), 8'(eb), 23'($urandom)};
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic rs;
    int base_cnt, n;
    reset = 1'b0;
    done_rand = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_sub = 1'b0; bus.in_tag = '0;
    bus.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0; bus16.in_sub = 1'b0;
    bus16.in_tag = '0; bus16.out_ready = 1'b1;
    #1 reset = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_result", bus.out_result, 32'd0);
    check("rst_out_tag", 32'(bus.out_tag), 32'd0);
    check("rst_out_inexact", 32'(bus.out_inexact), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;

    run_one("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 4'd5, 32'h40000000, 1'b0);
    run_one("one_minus_one", 32'h3F800000, 32'h3F800000, 1'b1, 4'd6, 32'h00000000, 1'b0);
    run_one("three_minus_zero", 32'h40400000, 32'h00000000, 1'b1, 4'd7, 32'h40400000, 1'b0);
    run_one("zero_minus_one", 32'h00000000, 32'h3F800000, 1'b1, 4'd8, 32'hBF800000, 1'b0);
    run_one("tie_even", 32'h3F800000, 32'h33800000, 1'b0, 4'd9, 32'h3F800000, 1'b1);
    run_one("tie_odd_up", 32'h3F800001, 32'h33800000, 1'b0, 4'd10, 32'h3F800002, 1'b1);
    run_one("shift_sat", 32'h3F800000, 32'h00800000, 1'b0, 4'd11, 32'h3F800000, 1'b1);
    run_one("one_minus_half_ulp", 32'h3F800000, 32'h33800000, 1'b1, 4'd12, 32'h3F7FFFFF, 1'b0);
    run_one("three_plus_neg", 32'h40400000, 32'hBFC00000, 1'b0, 4'd13, 32'h3FC00000, 1'b0);

    // backpressure: six back-to-back ops, output stalled 4 cycles
    base_cnt = out_count;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          gen_pair(ra, rb, rs);
          send_op(ra, rb, rs, 4'(k));
        end
      end
      begin
        n = 0;
        while (!bus.out_valid && n < 20) begin
          @(posedge clk);
          #1;
          n++;
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    check("bp_count", 32'(out_count - base_cnt), 32'd6);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // randomized traffic with random backpressure
    fork
      begin
        for (int k = 0; k < 400; k++) begin
          gen_pair(ra, rb, rs);
          send_op(ra, rb, rs, 4'(k));
          if ($urandom % 4 == 0) begin
            @(posedge clk);
            #1;
          end
        end
        done_rand = 1'b1;
      end
      begin
        while (!done_rand) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom % 4) != 0;
        end
      end
    join
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    // asynchronous reset with three ops in flight
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1; bus.in_a = 32'h3F800000; bus.in_b = 32'h40000000;
      bus.in_sub = 1'b0; bus.in_tag = 4'(k + 1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check("flight_out_valid", 32'(bus.out_valid), 32'd1);
    #3 reset = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_result", bus.out_result, 32'd0);
    check("async_rst_tag", 32'(bus.out_tag), 32'd0);
    check("async_rst_inexact", 32'(bus.out_inexact), 32'd0);
    check("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
      check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    end
    run_one("post_rst_cancel", 32'h40000000, 32'hC0000000, 1'b0, 4'd3, 32'h00000000, 1'b0);

    // FP16 instance
    bus16.in_valid = 1'b1; bus16.in_a = 16'h3C00; bus16.in_b = 16'h3C00;
    bus16.in_sub = 1'b0; bus16.in_tag = 4'd5;
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
    n = 1;
    while (!bus16.out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("fp16_latency", 32'(n), 32'd3);
    check("fp16_result", 32'(bus16.out_result), 32'h4000);
    check("fp16_tag", 32'(bus16.out_tag), 32'd5);
    check("fp16_inexact", 32'(bus16.out_inexact), 32'd0);
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
